// File: rtl/mc_cpu_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the 64-bit datapath.
// master: the sequencer. It samples opcode/zero/ready and drives enables, selects and status.
// slave:  the datapath/memory side, the mirror image of master.
interface mc_cpu_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  opcode, zero, imem_ready, dmem_ready,
    output pc_en, ir_write, reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
           pc_src, alu_op, illegal_op, bus_err, state
  );

  modport slave (
    output opcode, zero, imem_ready, dmem_ready,
    input  pc_en, ir_write, reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
           pc_src, alu_op, illegal_op, bus_err, state
  );
endinterface

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Memory waits in FETCH/MEM are bounded by MEM_TIMEOUT; expiry pulses bus_err and refetches.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   ctrl       : mc_cpu_ctrl_if.master (opcode, zero, ready inputs; enables, selects, status)
// Optional feature, macro MC_CPU_CTRL_PERF_EN: adds cycle_cnt, instr_cnt, stall_cnt (32-bit).
module mc_cpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_cpu_ctrl_if.master       ctrl
`ifdef MC_CPU_CTRL_PERF_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLd    = 6'h23;
  localparam logic [5:0] OpSd    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [CNT_W-1:0] Timeout = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             waiting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      cnt_q    <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    waiting         = 1'b0;
    ctrl.pc_en      = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.mem_read   = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.alu_src    = 1'b0;
    ctrl.reg_dst    = 1'b0;
    ctrl.mem_to_reg = 1'b0;
    ctrl.pc_src     = 2'b00;
    ctrl.alu_op     = 2'b00;
    ctrl.illegal_op = 1'b0;
    ctrl.bus_err    = 1'b0;
    ctrl.state      = state_q;

    // Outputs are forced low while reset is held, even if a ready input is high.
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          if (ctrl.imem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_en    = 1'b1;
            state_d       = StDecode;
          end else begin
            waiting = 1'b1;
            if (cnt_q >= Timeout) begin
              ctrl.bus_err = 1'b1;
              state_d      = StFetch;
            end
          end
        end
        StDecode: begin
          opcode_d = ctrl.opcode;
          case (ctrl.opcode)
            OpRtype, OpLd, OpSd, OpBeq, OpAddi, OpJ: state_d = StExec;
            default: begin
              ctrl.illegal_op = 1'b1;
              state_d         = StFetch;
            end
          endcase
        end
        StExec: begin
          case (opcode_q)
            OpRtype: begin
              ctrl.alu_op = 2'b10;
              state_d     = StWb;
            end
            OpAddi: begin
              ctrl.alu_src = 1'b1;
              state_d      = StWb;
            end
            OpLd, OpSd: begin
              ctrl.alu_src = 1'b1;
              state_d      = StMem;
            end
            OpBeq: begin
              ctrl.alu_op = 2'b01;
              ctrl.pc_src = 2'b01;
              ctrl.pc_en  = ctrl.zero;
              state_d     = StFetch;
            end
            OpJ: begin
              ctrl.pc_src = 2'b10;
              ctrl.pc_en  = 1'b1;
              state_d     = StFetch;
            end
            default: state_d = StFetch;
          endcase
        end
        StMem: begin
          if (!ctrl.dmem_ready) begin
            waiting = 1'b1;
          end
          // Abandoned access: drop the request in the cycle that reports the error.
          if (waiting && (cnt_q >= Timeout)) begin
            ctrl.bus_err = 1'b1;
            state_d      = StFetch;
          end else begin
            ctrl.mem_read  = (opcode_q == OpLd);
            ctrl.mem_write = (opcode_q == OpSd);
            ctrl.alu_src   = 1'b1;
            if (ctrl.dmem_ready) begin
              state_d = (opcode_q == OpLd) ? StWb : StFetch;
            end
          end
        end
        StWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = (opcode_q == OpRtype);
          ctrl.mem_to_reg = (opcode_q == OpLd);
          state_d         = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end

    // A bus_err refetch is a state change too, so the counter restarts from zero.
    if ((state_d != state_q) || ctrl.bus_err) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifdef MC_CPU_CTRL_PERF_EN
  logic instr_done;

  // Completed instructions only; illegal_op and bus_err exits are not counted.
  assign instr_done = (state_q == StWb) ||
                      ((state_q == StExec) && ((opcode_q == OpBeq) || (opcode_q == OpJ))) ||
                      ((state_q == StMem) && (opcode_q == OpSd) && ctrl.dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
      if (waiting)    stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
module tb_mc_cpu_ctrl;
  localparam int unsigned TO = 4;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
  localparam logic [5:0] OP_R = 6'h00, OP_LD = 6'h23, OP_SD = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_JUNK = 6'h3F;

  // {pc_en, ir_write, reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
  //  pc_src[1:0], alu_op[1:0], illegal_op, bus_err}
  localparam logic [13:0] O_NONE   = 14'b0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [13:0] O_FETCH  = 14'b1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [13:0] O_EX_R   = 14'b0_0_0_0_0_0_0_0_00_10_0_0;
  localparam logic [13:0] O_EX_I   = 14'b0_0_0_0_0_1_0_0_00_00_0_0;
  localparam logic [13:0] O_MEM_RD = 14'b0_0_0_1_0_1_0_0_00_00_0_0;
  localparam logic [13:0] O_MEM_WR = 14'b0_0_0_0_1_1_0_0_00_00_0_0;
  localparam logic [13:0] O_WB_R   = 14'b0_0_1_0_0_0_1_0_00_00_0_0;
  localparam logic [13:0] O_WB_I   = 14'b0_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [13:0] O_WB_L   = 14'b0_0_1_0_0_0_0_1_00_00_0_0;
  localparam logic [13:0] O_BEQ_T  = 14'b1_0_0_0_0_0_0_0_01_01_0_0;
  localparam logic [13:0] O_BEQ_N  = 14'b0_0_0_0_0_0_0_0_01_01_0_0;
  localparam logic [13:0] O_J      = 14'b1_0_0_0_0_0_0_0_10_00_0_0;
  localparam logic [13:0] O_ILL    = 14'b0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [13:0] O_BERR   = 14'b0_0_0_0_0_0_0_0_00_00_0_1;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [13:0] o;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [13:0] o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  vec_t tbl[$];
  exp_t sb[$];
  logic [13:0] outs;

  mc_cpu_ctrl_if ctrl ();

`ifdef MC_CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

  mc_cpu_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl.master)
`ifdef MC_CPU_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  assign outs = {ctrl.pc_en, ctrl.ir_write, ctrl.reg_write, ctrl.mem_read, ctrl.mem_write,
                 ctrl.alu_src, ctrl.reg_dst, ctrl.mem_to_reg, ctrl.pc_src, ctrl.alu_op,
                 ctrl.illegal_op, ctrl.bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic ir, input logic dr,
                     input logic [2:0] st, input logic [13:0] o);
    vec_t v;
    v.op = op; v.z = z; v.ir = ir; v.dr = dr; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic ir, input logic dr);
    ctrl.opcode     = op;
    ctrl.zero       = z;
    ctrl.imem_ready = ir;
    ctrl.dmem_ready = dr;
  endtask

  // One fetch plus decode of the given opcode; junk opcode elsewhere proves opcode_q is used.
  task automatic add_fd(input logic [5:0] op, input logic [13:0] dec_o);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_F, O_FETCH);
    add(op,      1'b0, 1'b1, 1'b1, S_D, dec_o);
  endtask

  initial begin
    exp_t e;
    int   rw_seen;
    n_chk = 0;
    n_err = 0;

    // RTYPE
    add_fd(OP_R, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_EX_R);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_W, O_WB_R);
    // LD with three MEM wait cycles
    add_fd(OP_LD, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_E, O_EX_I);
    for (int i = 0; i < 3; i++) add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_M, O_MEM_RD);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_M, O_MEM_RD);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_W, O_WB_L);
    // BEQ taken, preceded by one FETCH stall
    add(OP_JUNK, 1'b0, 1'b0, 1'b1, S_F, O_NONE);
    add_fd(OP_BEQ, O_NONE);
    add(OP_JUNK, 1'b1, 1'b1, 1'b1, S_E, O_BEQ_T);
    // BEQ not taken
    add_fd(OP_BEQ, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_BEQ_N);
    // Illegal opcode
    add_fd(OP_JUNK, O_ILL);
    // J
    add_fd(OP_J, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_J);
    // ADDI
    add_fd(OP_ADDI, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_EX_I);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_W, O_WB_I);
    // SD, ready at once
    add_fd(OP_SD, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_EX_I);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_M, O_MEM_WR);
    // SD timeout: TO wait cycles then bus_err
    add_fd(OP_SD, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_E, O_EX_I);
    for (int i = 0; i < TO; i++) add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_M, O_MEM_WR);
    add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_M, O_BERR);
    // FETCH timeout
    for (int i = 0; i < TO; i++) add(OP_JUNK, 1'b0, 1'b0, 1'b1, S_F, O_NONE);
    add(OP_JUNK, 1'b0, 1'b0, 1'b1, S_F, O_BERR);
    add_fd(OP_R, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_E, O_EX_R);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_W, O_WB_R);
    // SD where ready arrives as the counter reaches the limit: ready wins
    add_fd(OP_SD, O_NONE);
    add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_E, O_EX_I);
    for (int i = 0; i < TO; i++) add(OP_JUNK, 1'b0, 1'b1, 1'b0, S_M, O_MEM_WR);
    add(OP_JUNK, 1'b0, 1'b1, 1'b1, S_M, O_MEM_WR);
    add(OP_JUNK, 1'b0, 1'b0, 1'b1, S_F, O_NONE);

    // Reset, with imem_ready high to show outputs stay gated low
    rst_n = 1'b0;
    drive(OP_R, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(outs), 32'(O_NONE));
    check("reset_state", 32'(ctrl.state), 32'(S_F));
    drive(OP_JUNK, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Table run through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].op, tbl[i].z, tbl[i].ir, tbl[i].dr);
      e.idx = i; e.st = tbl[i].st; e.o = tbl[i].o;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard_empty row %0d: got no entry, required one", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("row%0d_state", e.idx), 32'(ctrl.state), 32'(e.st));
        check($sformatf("row%0d_outs", e.idx), 32'(outs), 32'(e.o));
      end
    end

    // Reset in the middle of an LD MEM wait
    @(posedge clk); #1 drive(OP_JUNK, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 drive(OP_LD, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 drive(OP_JUNK, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midmem_state", 32'(ctrl.state), 32'(S_M));
    check("midmem_mem_read", 32'(ctrl.mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_mem_read", 32'(ctrl.mem_read), 32'd0);
    check("async_rst_outs", 32'(outs), 32'(O_NONE));
    check("async_rst_state", 32'(ctrl.state), 32'(S_F));
    @(negedge clk);
    drive(OP_JUNK, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    rw_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ctrl.reg_write) rw_seen++;
      check($sformatf("post_rst_state%0d", i), 32'(ctrl.state), 32'(S_F));
    end
    check("post_rst_no_reg_write", 32'(rw_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_cpu_ctrl.md
Name: mc_cpu_ctrl

Overview:
- Multi-cycle sequencer for the 64-bit CPU datapath.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath enable and mux select.
- Waits on ready handshakes from the instruction and data memories, and bounds each wait with a timeout.
- Replaces the single-cycle control unit so the PC, register file and data memory can tolerate multi-cycle memory latency.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent waiting on a memory ready before the access is abandoned; must be at least 1.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register output.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory read data valid, or write accepted, this cycle.
- pc_en  out  1  PC load.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- alu_src  out  1  0 = readData2, 1 = sign-extended immediate.
- reg_dst  out  1  0 = instruction[20:16], 1 = instruction[15:11].
- mem_to_reg  out  1  0 = ALU result, 1 = memory data.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode from funct.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  one-cycle pulse on a memory timeout.
- state  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: state = FETCH; wait counter = 0; opcode_q = 0; every output 0.
- Output decode: outputs are decoded from the state register and opcode_q, which is latched on the DECODE cycle. No output depends combinationally on opcode outside DECODE.
- Supported opcodes: RTYPE 0x00, LD 0x23, SD 0x2B, BEQ 0x04, ADDI 0x08, J 0x02.

State transitions:
- FETCH: hold until imem_ready. In the ready cycle, pulse ir_write = 1 and pc_en = 1 with pc_src = 00, then go to DECODE.
- DECODE:
  - Latch opcode into opcode_q.
  - Undefined opcode: pulse illegal_op, go to FETCH (instruction acts as a NOP).
  - Any supported opcode: go to EXEC.
- EXEC, by opcode_q:
  - RTYPE: alu_op = 10, alu_src = 0; go to WB.
  - ADDI: alu_op = 00, alu_src = 1; go to WB.
  - LD, SD: alu_op = 00, alu_src = 1; go to MEM.
  - BEQ: alu_op = 01, alu_src = 0, pc_src = 01, pc_en = zero; go to FETCH.
  - J: pc_src = 10, pc_en = 1; go to FETCH.
- MEM:
  - Hold mem_read (LD) or mem_write (SD) high, together with alu_op = 00 and alu_src = 1.
  - When dmem_ready arrives: LD goes to WB; SD goes to FETCH.
- WB:
  - reg_write = 1 for one cycle, then go to FETCH.
  - RTYPE: reg_dst = 1, mem_to_reg = 0.
  - ADDI: reg_dst = 0, mem_to_reg = 0.
  - LD: reg_dst = 0, mem_to_reg = 1.

Wait counter and timeout:
- The counter clears on every state change and increments each cycle spent in FETCH or MEM without ready.
- When the counter reaches MEM_TIMEOUT with ready still low, pulse bus_err and go to FETCH. No state-changing output is asserted: reg_write, pc_en and ir_write all stay 0 and the PC keeps its value.
- If ready arrives in the same cycle the counter reaches MEM_TIMEOUT, ready wins and bus_err stays 0.

Latency with ready on first request:
- RTYPE, ADDI, SD: 4 cycles.
- LD: 5 cycles.
- BEQ, J: 3 cycles.

Boundary rules:
- Exactly one pc_en pulse in FETCH per instruction.
- At most one additional pc_en, in EXEC, for BEQ and J.
- mem_read and mem_write are never high together.
- Reset asserted mid-instruction: all outputs go to 0 immediately and the FSM restarts in FETCH. No partial register write occurs.
- The state encoding {FETCH, DECODE, EXEC, MEM, WB} uses 3 bits; any unused encoding returns to FETCH on the next clock.

Optional Feature:
- Macro: MC_CPU_CTRL_PERF_EN.
- When defined, adds these ports:
  - cycle_cnt  out  32: counts every clock out of reset.
  - instr_cnt  out  32: increments on each return to FETCH that follows a WB, a completed MEM for SD, or EXEC for BEQ/J. It does not count illegal_op or bus_err exits.
  - stall_cnt  out  32: counts cycles in FETCH/MEM with ready low.
- All three counters reset to 0 and wrap at 2^32.
- When not defined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then an RTYPE opcode with imem_ready and dmem_ready tied high. Required: state sequence FETCH, DECODE, EXEC, WB, FETCH; reg_write = 1 only in WB with reg_dst = 1; alu_op = 10 in EXEC.
- LD with dmem_ready low for 3 MEM cycles. Required: mem_read high for 4 cycles, then WB with mem_to_reg = 1; with the macro defined, stall_cnt = 3.
- BEQ with zero = 1, then BEQ with zero = 0. Required: EXEC shows pc_src = 01 with pc_en = 1 for the first and pc_en = 0 for the second; 3 cycles each.
- Opcode 0x3F. Required: illegal_op pulses 1 cycle in DECODE, FSM returns to FETCH, reg_write is never asserted.
- SD with dmem_ready held low and MEM_TIMEOUT = 4. Required: bus_err pulses after 4 MEM cycles, mem_write drops, FSM is in FETCH, no pc_en pulse in that window.
- rst_n driven low mid-MEM during an LD. Required: mem_read falls to 0 asynchronously, state = FETCH after release, no reg_write follows.
